uart_rx_ctrl: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width and sizing helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    // Bit-period counter only ever holds values up to CLKS_PER_BIT-1.
    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

    // One extra pointer bit separates full from empty when the indices match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small show-ahead FIFO: head always presents the oldest entry.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array is reset too, so head reads 0 straight out of reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART frame receiver: baud-timed mid-bit sampling into a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                 sync1;
    logic                 rxs;
    logic                 rxs_prev;
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 cnt_zero;
    logic                 parity_ok;
    logic                 good_byte;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync1    <= rx;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign parity_ok = ~(^shreg ^ par_bit);
`else
    assign parity_ok = 1'b1;
`endif

    assign cnt_zero  = (cnt == '0);
    assign fifo_pop  = rx_valid && rx_ready;
    assign good_byte = (state == STOP) && cnt_zero && rxs && parity_ok;
    assign fifo_push = good_byte && (!fifo_full || fifo_pop);
    assign rx_valid  = !fifo_empty;

    // NOTE: state, counters and status pulses all update with non-blocking assignments in one clocked block.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Only a falling edge starts a frame; a held-low line is ignored.
                    if (rxs_prev && !rxs) begin
                        state <= START;
                        cnt   <= HALF_BIT;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!rxs) begin
                        state   <= DATA;
                        cnt     <= FULL_BIT;
                        bit_idx <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DATA: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        shreg[bit_idx] <= rxs;
                        cnt            <= FULL_BIT;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        par_bit <= rxs;
                        cnt     <= FULL_BIT;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (!parity_ok) begin
                            parity_err <= 1'b1;
`endif
                        end else if (fifo_full && !fifo_pop) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_BITS)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .push     (fifo_push),
        .push_data(shreg),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (rx_data)
    );

endmodule
